// File: rtl/sistema_speed_pkg.sv
// Shared definitions for the sistema_speed full-adder BIST: state encoding,
// sweep size and the golden full-adder functions.
package sistema_speed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } bist_state_t;

    localparam int VEC_COUNT = 8;

    // Golden model written out directly so a faulty adder cannot check itself.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sistema_speed_bist_vecgen.sv
// Vector and pass counter with a wait-cycle timer; holds each vector for
// DUT_LAT+1 cycles and flags the sampling cycle and the final sample of a run.
module sistema_speed_bist_vecgen
    import sistema_speed_pkg::*;
#(
    parameter int DUT_LAT = 0,
    parameter int PASSES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run_en,
    output logic [2:0] vec,
    output logic       sample_en,
    output logic       last
);

    localparam int TW = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [TW-1:0] LAT_MAX  = TW'(DUT_LAT);
    localparam logic [PW-1:0] PASS_MAX = PW'(PASSES - 1);
    localparam logic [2:0]    VEC_MAX  = 3'(VEC_COUNT - 1);

    logic [TW-1:0] timer;
    logic [PW-1:0] pass_idx;

    assign sample_en = run_en && (timer == LAT_MAX);
    assign last      = sample_en && (vec == VEC_MAX) && (pass_idx == PASS_MAX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vec      <= '0;
            timer    <= '0;
            pass_idx <= '0;
        end else if (run_en) begin
            if (sample_en) begin
                timer <= '0;
                vec   <= vec + 3'd1;
                if (vec == VEC_MAX) begin
                    pass_idx <= last ? '0 : pass_idx + PW'(1);
                end
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/sistema_speed_bist.sv
// Built-in self-test controller for the sistema_speed full adder: sweeps all
// input vectors, checks s/carry against the golden model, reports status.
module sistema_speed_bist
    import sistema_speed_pkg::*;
#(
    parameter int DUT_LAT = 0,
    parameter int PASSES  = 1,
    parameter int ERR_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_s,
    input  logic             dut_carry,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       fail_vec,
    output logic             fail_valid
);

    bist_state_t state;
    logic [2:0]  vec;
    logic        sample_en;
    logic        last;
    logic        mismatch;

    sistema_speed_bist_vecgen #(
        .DUT_LAT (DUT_LAT),
        .PASSES  (PASSES)
    ) u_vecgen (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .run_en    (state == APPLY),
        .vec       (vec),
        .sample_en (sample_en),
        .last      (last)
    );

    // The vector register is the stimulus, so the adder inputs only move on advance.
    assign {dut_a, dut_b, dut_c} = vec;

    assign mismatch = (dut_s     != fa_sum  (vec[2], vec[1], vec[0])) ||
                      (dut_carry != fa_carry(vec[2], vec[1], vec[0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= APPLY;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                    end
                end
                APPLY: begin
                    if (sample_en) begin
                        if (mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (!fail_valid) begin
                                fail_vec   <= vec;
                                fail_valid <= 1'b1;
                            end
                        end
                        if (last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sistema_speed_bist.sv
// Self-checking bench for sistema_speed_bist: a fault-injectable adder model
// feeds the controller, and a sweep-level reference predicts each run's result.
module tb_sistema_speed_bist;

    localparam int LAT   = 1;
    localparam int NPASS = 2;
    localparam int EW    = 3;
    localparam int RUN_CYCLES = 8 * NPASS * (LAT + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          dut_s, dut_carry;
    logic          dut_a, dut_b, dut_c;
    logic          busy, done, pass;
    logic [EW-1:0] err_count;
    logic [2:0]    fail_vec;
    logic          fail_valid;

    logic [7:0] s_flip = 8'h00;
    logic [7:0] c_flip = 8'h00;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sistema_speed_bist #(
        .DUT_LAT (LAT),
        .PASSES  (NPASS),
        .ERR_W   (EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dut_s      (dut_s),
        .dut_carry  (dut_carry),
        .dut_a      (dut_a),
        .dut_b      (dut_b),
        .dut_c      (dut_c),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid)
    );

    // Adder under test: arithmetic full adder with per-vector fault masks.
    always_comb begin
        int ones;
        logic [2:0] v;
        v    = {dut_a, dut_b, dut_c};
        ones = int'(dut_a) + int'(dut_b) + int'(dut_c);
        dut_s     = ((ones % 2) == 1) ^ s_flip[v];
        dut_carry = (ones >= 2) ^ c_flip[v];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // One full run: start pulse, per-cycle stimulus check, latency and final status.
    task automatic applyStimulus(input logic [7:0] sm, input logic [7:0] cm, input bit poke);
        int done_at;
        int nf;
        int first;
        int exp_err;
        s_flip = sm;
        c_flip = cm;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_rise", busy, 1);
        checkOutput("cleared_on_start", {pass, fail_valid, err_count}, 0);
        done_at = -1;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_at = k;
                break;
            end
            if (k < RUN_CYCLES)
                checkOutput("stim_vec", {dut_a, dut_b, dut_c}, (k / (LAT + 1)) % 8);
            else if (k == RUN_CYCLES)
                checkOutput("stim_done_zero", {dut_a, dut_b, dut_c}, 0);
            if (poke && (k == 5 || k == RUN_CYCLES)) start = 1'b1;
        end
        checkOutput("latency", done_at, RUN_CYCLES + 1);

        nf = 0;
        first = -1;
        for (int v = 0; v < 8; v++) begin
            if (sm[v] | cm[v]) begin
                nf++;
                if (first < 0) first = v;
            end
        end
        exp_err = (nf * NPASS > (2 ** EW) - 1) ? (2 ** EW) - 1 : nf * NPASS;
        checkOutput("err_count", err_count, exp_err);
        checkOutput("fail_valid", fail_valid, first >= 0);
        checkOutput("fail_vec", fail_vec, (first < 0) ? 0 : first);
        checkOutput("pass", pass, nf == 0);
        checkOutput("busy_at_done", busy, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("no_restart", busy, 0);
    endtask

    initial begin
        int pulses;
        int seen;
        $display("[TB] sistema_speed_bist bench, DUT_LAT=%0d PASSES=%0d ERR_W=%0d", LAT, NPASS, EW);
        repeat (2) @(negedge clk);
        checkOutput("reset_state", {busy, done, pass, fail_valid, err_count, fail_vec, dut_a, dut_b, dut_c}, 0);
        reset = 1'b0;

        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'b1110_1000, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0);
        for (int r = 0; r < 4; r++) begin
            logic [7:0] sm;
            logic [7:0] cm;
            sm = 8'($urandom) & 8'($urandom);
            cm = 8'($urandom) & 8'($urandom) & 8'($urandom);
            $display("[TB] random run %0d: s mask %02h carry mask %02h", r, sm, cm);
            applyStimulus(sm, cm, 1'b0);
        end
        applyStimulus(8'h00, 8'h00, 1'b1);
        applyStimulus(8'h00, 8'b1000_0000, 1'b0);

        // Reset in the middle of a faulty run, while vector 101 is applied.
        s_flip = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5 * (LAT + 1)) @(negedge clk);
        checkOutput("stim_before_reset", {dut_a, dut_b, dut_c}, 5);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_run_reset", {busy, done, pass, fail_valid, err_count, fail_vec, dut_a, dut_b, dut_c}, 0);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < RUN_CYCLES + 8; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("no_done_after_reset", pulses, 0);
        applyStimulus(8'h00, 8'h00, 1'b0);

        // Start held high: a new run begins on the IDLE cycle after DONE.
        s_flip = 8'h00;
        c_flip = 8'h00;
        @(negedge clk);
        start = 1'b1;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("held_first_done", seen, 1);
        @(negedge clk);
        checkOutput("held_restart_busy", busy, 1);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("held_second_done", seen, 1);
        checkOutput("held_second_pass", pass, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sistema_speed_bist.md
Name: sistema_speed_bist

Overview:
- Synthesizable built-in self-test controller for the sistema_speed full adder (inputs a, b, c; outputs s, carry).
- Drives every 3-bit input vector into the adder under test, waits a configurable latency, then samples s/carry.
- Compares each sample against a golden model, counts mismatches and captures the first failing vector.
- Sits beside the adder in the hashing datapath and gives a start/busy/done/pass status handshake to the system controller.

Parameters:
- DUT_LAT, 0, extra wait cycles between applying a vector and sampling the adder outputs (0 = combinational DUT).
- PASSES, 1, number of full sweeps over vectors 0..7 per run (≥1).
- ERR_W, 4, width of the saturating mismatch counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  run request, sampled only in IDLE
- dut_s  input  1  sum output from adder under test
- dut_carry  input  1  carry output from adder under test
- dut_a  output  1  registered stimulus bit a (vector bit 2)
- dut_b  output  1  registered stimulus bit b (vector bit 1)
- dut_c  output  1  registered stimulus bit c (vector bit 0)
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  high after a run with zero mismatches; held until next start
- err_count  output  ERR_W  mismatch count, saturating at all-ones
- fail_vec  output  3  first failing vector {a,b,c}
- fail_valid  output  1  fail_vec holds a captured failure

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; vector and pass counters 0.
- States: IDLE, APPLY, DONE.
- IDLE:
  - start=1 → APPLY with vec=0 and pass_idx=0.
  - Clears err_count, fail_vec, fail_valid and pass.
  - busy rises on the same edge.
- APPLY:
  - {dut_a,dut_b,dut_c}=vec for exactly DUT_LAT+1 cycles.
  - On the edge ending the last cycle, compare dut_s against a^b^c and dut_carry against majority(a,b,c).
  - On mismatch, increment err_count, saturating at 2^ERR_W-1.
  - On the first mismatch of the run, capture fail_vec=vec and set fail_valid; later mismatches never overwrite it.
  - Then vec increments modulo 8. Wrap from 7 to 0 increments pass_idx.
  - Wrap with pass_idx=PASSES-1 → DONE.
- DONE (1 cycle):
  - done=1, busy=0, pass=(err_count==0), stimulus returns to 000.
  - Next cycle → IDLE.
- Latency: start edge to done pulse = 8·PASSES·(DUT_LAT+1)+1 cycles.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new run begins on the IDLE cycle after DONE.
- Reset mid-run: aborts on the next edge, all outputs to reset values, no done pulse.
- Mismatch on the final vector is counted before DONE evaluates pass.
- Stimulus outputs are registered, glitch-free, and change only on vector advance.

Decomposition:
- Shared package sistema_speed_pkg holds:
  - state encoding (IDLE=2'd0, APPLY=2'd1, DONE=2'd2);
  - constant VEC_COUNT=8;
  - golden functions fa_sum(a,b,c) and fa_carry(a,b,c).
- The golden model is deliberately not an instance of sistema_speed, so a fault in the adder cannot mask itself.
- One sub-module is natural: sistema_speed_bist_vecgen, the vector/pass counter with wait-cycle timer, emitting vec, sample_en and last.

Test Plan:
- Golden adder, DUT_LAT=0, PASSES=1: pulse start → vectors 000..111 each held 1 cycle; done at cycle 9; pass=1; err_count=0; fail_valid=0.
- Carry stuck-at-0 → mismatches at 011, 101, 110, 111; err_count=4; fail_vec=011; fail_valid=1; pass=0.
- DUT_LAT=2, PASSES=3, golden adder → each vector held 3 cycles; done at cycle 73; pass=1.
- ERR_W=2 with s inverted (8 mismatches per pass) → err_count saturates at 3; fail_vec=000.
- Assert reset mid-run at vector 101 → next cycle all outputs 0; no done pulse; a following start runs a clean full sweep.
- Pulse start again during APPLY and during DONE → ignored; exactly one done pulse; vector sequence unchanged.
